uz_nn_acc_hls_deadlock_monitor: RTL and testbench

Per-process deadlock detection node for the NN accelerator's HLS dataflow region, one instance per dataflow process. Merges blocked-dependency vectors from upstream channels, forwards its own dependency set downstream, and passes the report token. Generalises the single-cycle detector: a cycle must persist for `CONFIRM_CYCLES` consecutive cycles before it is reported, and the report is registered, latched with a snapshot, and counted. Output is held until a debug master acknowledges it.

---
 rtl/uz_nn_acc_hls_deadlock_monitor.sv | 126 ++++++++++++
 tb/tb_uz_nn_acc_hls_deadlock_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uz_nn_acc_hls_deadlock_monitor.sv
// Per-process deadlock detection node for an HLS dataflow region: merges upstream
// dependency vectors, confirms a self-dependency over CONFIRM_CYCLES, then reports and holds.
module uz_nn_acc_hls_deadlock_monitor #(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int CONFIRM_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  input  logic                            report_ack,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic [PROC_NUM-1:0]             dl_snapshot,
  output logic [OUT_CHAN_NUM-1:0]         dl_chan_vec,
  output logic [CNT_W-1:0]                dl_count
);

  localparam int                   CW           = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CW-1:0]        CONFIRM_LAST = CW'(CONFIRM_CYCLES - 1);
  localparam logic [PROC_NUM-1:0]  SELF_BIT     = PROC_NUM'(1) << PROC_ID;

  typedef enum logic [1:0] {IDLE, CONFIRM, REPORT, HOLDOFF} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [PROC_NUM-1:0] dep_reg;
  logic [PROC_NUM-1:0] dep_in;
  logic [PROC_NUM-1:0] dep;
  logic                blocked;
  logic                gate;
  logic                hit;
  logic                report_go;
  logic                token_pass;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    dep_in = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (in_chan_dep_vld_vec[i]) dep_in = dep_in | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
    end
  end

  // While a deadlock is already flagged globally, only a token-carrying cycle may refresh dep.
  assign blocked    = |proc_dep_vld_vec;
  assign gate       = ~dl_detect_in | (|token_in_vec);
  assign dep        = gate ? dep_in : dep_reg;
  assign hit        = gate & dep[PROC_ID] & blocked;
  assign token_pass = ((|token_in_vec) & ~token_clear) | origin;
  assign report_go  = hit & (((state == IDLE) && (CONFIRM_CYCLES == 1)) ||
                             ((state == CONFIRM) && (cnt == CONFIRM_LAST)));

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg | SELF_BIT;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dep_reg       <= '0;
      token_out_vec <= '0;
      dl_detect_out <= 1'b0;
      dl_snapshot   <= '0;
      dl_chan_vec   <= '0;
      dl_count      <= '0;
    end else begin
      dep_reg       <= blocked ? dep : '0;
      token_out_vec <= token_pass ? proc_dep_vld_vec : '0;

      if (report_go) begin
        dl_snapshot   <= dep;
        dl_chan_vec   <= proc_dep_vld_vec;
        dl_detect_out <= 1'b1;
        if (dl_count != {CNT_W{1'b1}}) dl_count <= dl_count + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (hit) begin
            if (CONFIRM_CYCLES == 1) begin
              state <= REPORT;
            end else begin
              state <= CONFIRM;
              cnt   <= CW'(1);
            end
          end
        end
        CONFIRM: begin
          if (!hit) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CONFIRM_LAST) begin
            state <= REPORT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REPORT: begin
          if (report_ack) begin
            dl_detect_out <= 1'b0;
            state         <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          // Re-arm only once the process has actually unblocked.
          if (!blocked) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uz_nn_acc_hls_deadlock_monitor.sv
// Scoreboard bench: two monitors (CNT_W 8 and 2) share stimulus; expected reports are
// queued by the stimulus and popped by a monitor on each dl_detect_out rising edge.
module tb_uz_nn_acc_hls_deadlock_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] proc_dep;
  logic [1:0] in_vld;
  logic [7:0] in_data;
  logic [1:0] token_in;
  logic       dl_in, origin, token_clear, report_ack;

  logic [2:0] vld_a, vld_b, tok_a, tok_b, chan_a, chan_b;
  logic [3:0] data_a, data_b, snap_a, snap_b;
  logic       det_a, det_b;
  logic [7:0] count_a;
  logic [1:0] count_b;

  typedef struct {
    logic [3:0] snap;
    logic [2:0] chan;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   exp_a = 0;
  int   exp_b = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  uz_nn_acc_hls_deadlock_monitor #(
    .PROC_NUM(4), .PROC_ID(1), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3), .CONFIRM_CYCLES(3), .CNT_W(8)
  ) dut_a (
    .clock(clock), .reset(reset), .proc_dep_vld_vec(proc_dep), .in_chan_dep_vld_vec(in_vld),
    .in_chan_dep_data_vec(in_data), .token_in_vec(token_in), .dl_detect_in(dl_in),
    .origin(origin), .token_clear(token_clear), .report_ack(report_ack),
    .out_chan_dep_vld_vec(vld_a), .out_chan_dep_data(data_a), .token_out_vec(tok_a),
    .dl_detect_out(det_a), .dl_snapshot(snap_a), .dl_chan_vec(chan_a), .dl_count(count_a)
  );

  uz_nn_acc_hls_deadlock_monitor #(
    .PROC_NUM(4), .PROC_ID(1), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3), .CONFIRM_CYCLES(3), .CNT_W(2)
  ) dut_b (
    .clock(clock), .reset(reset), .proc_dep_vld_vec(proc_dep), .in_chan_dep_vld_vec(in_vld),
    .in_chan_dep_data_vec(in_data), .token_in_vec(token_in), .dl_detect_in(dl_in),
    .origin(origin), .token_clear(token_clear), .report_ack(report_ack),
    .out_chan_dep_vld_vec(vld_b), .out_chan_dep_data(data_b), .token_out_vec(tok_b),
    .dl_detect_out(det_b), .dl_snapshot(snap_b), .dl_chan_vec(chan_b), .dl_count(count_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of dl_detect_out must match the oldest queued report.
  logic prev_det = 1'b0;
  always @(negedge clock) begin
    if (det_a && !prev_det) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_report: report at cycle %0d, none expected", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rpt_cycle", cyc, e.cyc);
        check("rpt_snapshot", snap_a, e.snap);
        check("rpt_chan_vec", chan_a, e.chan);
        check("rpt_count_a", count_a, e.cnt_a);
        check("rpt_count_b", count_b, e.cnt_b);
        check("rpt_det_b", det_b, 1);
      end
    end
    prev_det = det_a;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_report(input logic [3:0] snap, input logic [2:0] chan);
    exp_t e;
    exp_a = (exp_a == 255) ? 255 : exp_a + 1;
    exp_b = (exp_b == 3) ? 3 : exp_b + 1;
    e.snap  = snap;
    e.chan  = chan;
    e.cnt_a = 8'(exp_a);
    e.cnt_b = 2'(exp_b);
    e.cyc   = cyc + 3;
    q.push_back(e);
  endtask

  task automatic drive_hit();
    proc_dep = 3'b001;
    in_vld   = 2'b01;
    in_data  = 8'b0000_0010;
  endtask

  task automatic release_report();
    report_ack = 1'b1;
    step();
    report_ack = 1'b0;
    check("ack_drop_a", det_a, 0);
    check("ack_drop_b", det_b, 0);
    proc_dep = 3'b000;
    in_vld   = 2'b00;
    step();
  endtask

  int sat_tab[4] = '{2, 3, 3, 3};

  initial begin
    reset = 1'b1; proc_dep = '0; in_vld = '0; in_data = '0; token_in = '0;
    dl_in = 1'b0; origin = 1'b0; token_clear = 1'b0; report_ack = 1'b0;
    step(2);
    reset = 1'b0;
    check("rst_det", det_a, 0);
    check("rst_token", tok_a, 0);
    check("rst_snapshot", snap_a, 0);
    check("rst_count", count_a, 0);
    check("rst_dep_data", data_a, 4'b0010);

    // Confirmed report from two merged channels; ack on the entry edge is ignored.
    drive_hit();
    in_vld  = 2'b11;
    in_data = 8'b1000_0010;
    expect_report(4'b1010, 3'b001);
    check("dep_vld_passthru", vld_a, 3'b001);
    step();
    check("dep_data_merged", data_a, 4'b1010);
    step();
    report_ack = 1'b1;
    step();
    report_ack = 1'b0;
    step(10);
    check("report_held", det_a, 1);
    report_ack = 1'b1;
    step();
    report_ack = 1'b0;
    check("ack_drop", det_a, 0);
    step(5);
    check("holdoff_no_rereport", det_a, 0);
    proc_dep = 3'b000;
    step();
    proc_dep = 3'b001;
    expect_report(4'b1010, 3'b001);
    step(4);
    check("rereport", det_a, 1);
    release_report();

    // A single gap cycle restarts confirmation.
    drive_hit();
    step(2);
    in_vld = 2'b00;
    step();
    check("gap_no_report", det_a, 0);
    drive_hit();
    expect_report(4'b0010, 3'b001);
    step(4);
    release_report();

    // Token path.
    origin = 1'b1; proc_dep = 3'b101;
    step();
    check("token_origin", tok_a, 3'b101);
    origin = 1'b0; token_in = 2'b01; token_clear = 1'b1;
    step();
    check("token_cleared", tok_a, 3'b000);
    token_clear = 1'b0;
    step();
    check("token_forward", tok_a, 3'b101);
    origin = 1'b1; token_clear = 1'b1; token_in = 2'b00;
    step();
    check("origin_over_clear", tok_a, 3'b101);
    origin = 1'b0; token_clear = 1'b0; token_in = 2'b10; proc_dep = 3'b011;
    step();
    check("token_chan1", tok_a, 3'b011);
    token_in = 2'b00;
    step();
    check("token_idle", tok_a, 3'b000);

    // Global deadlock flag with no token freezes dep at dep_reg.
    proc_dep = 3'b001; in_vld = 2'b01; in_data = 8'b0000_0100;
    step();
    check("dep_reg_load", data_a, 4'b0110);
    dl_in = 1'b1; in_data = 8'b0000_0010;
    step(5);
    check("dep_frozen", data_a, 4'b0110);
    check("frozen_no_hit", det_a, 0);
    dl_in = 1'b0; in_vld = 2'b00; proc_dep = 3'b000;
    step();

    // Reset during CONFIRM with cnt=2.
    origin = 1'b1;
    drive_hit();
    step(2);
    check("pre_rst_token", tok_a, 3'b001);
    reset = 1'b1;
    #1;
    check("async_rst_token", tok_a, 0);
    check("async_rst_det", det_a, 0);
    check("async_rst_snapshot", snap_a, 0);
    check("async_rst_chan", chan_a, 0);
    check("async_rst_count_a", count_a, 0);
    check("async_rst_count_b", count_b, 0);
    check("async_rst_dep_data", data_a, 4'b0010);
    exp_a = 0;
    exp_b = 0;
    origin = 1'b0;
    step();
    reset = 1'b0;
    expect_report(4'b0010, 3'b001);
    step(4);
    release_report();

    // Saturation of the 2-bit counter over further reports.
    for (int k = 0; k < 4; k++) begin
      drive_hit();
      expect_report(4'b0010, 3'b001);
      step(4);
      check("count_sat_b", count_b, sat_tab[k]);
      release_report();
    end

    step(2);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
